// File: rtl/bitset_encoder.sv
// Sequential N:log2(N) encoder: drains the set bits of an accepted vector as
// binary indices, lowest first. Define BITSET_ENC_LAST_EN to add the out_last port.
module bitset_encoder #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef BITSET_ENC_LAST_EN
  output logic [W-1:0] out_idx,
  output logic         out_last
`else
  output logic [W-1:0] out_idx
`endif
);

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t         r_state, w_state_nxt;
  logic [N-1:0]   r_pend, w_pend_nxt;
  logic [N-1:0]   w_pend_clr;
  logic [W-1:0]   w_idx;
  logic           w_accept, w_fire;

  // Priority scan from the top so the lowest set bit wins; 0 when pend is empty.
  always_comb begin
    w_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r_pend[i]) w_idx = W'(i);
    end
  end

  assign w_pend_clr = r_pend & (r_pend - N'(1));
  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == DRAIN);
  assign out_idx    = w_idx;
  assign w_accept   = in_valid & in_ready;
  assign w_fire     = out_valid & out_ready;

`ifdef BITSET_ENC_LAST_EN
  // Exactly one bit left: clearing the lowest one empties the vector.
  assign out_last = out_valid & (r_pend != '0) & (w_pend_clr == '0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    unique case (r_state)
      IDLE: begin
        // An all-zero vector is consumed without producing a beat.
        if (w_accept && (in_vec != '0)) begin
          w_pend_nxt  = in_vec;
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_fire) begin
          w_pend_nxt = w_pend_clr;
          if (w_pend_clr == '0) w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_pend_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

endmodule

// File: tb/tb_bitset_encoder.sv
// Self-checking bench for bitset_encoder: directed boundary steps then random
// traffic, compared against a queue-of-indices reference model.
module tb_bitset_encoder;
  localparam int N = 4;
  localparam int W = $clog2(N);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [N-1:0] in_vec = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] out_idx;
`ifdef BITSET_ENC_LAST_EN
  logic         out_last;
`endif

  bitset_encoder #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef BITSET_ENC_LAST_EN
    .out_idx(out_idx), .out_last(out_last)
`else
    .out_idx(out_idx)
`endif
  );

  always #5 clk = ~clk;

  // Reference: indices still owed to the consumer, in emission order.
  int unsigned q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(q.size() == 0));
    chk({tag, ".out_idx"},   32'(out_idx),   (q.size() != 0) ? q[0] : 32'd0);
`ifdef BITSET_ENC_LAST_EN
    chk({tag, ".out_last"},  32'(out_last),  32'(q.size() == 1));
`endif
  endtask

  // One clock: drive inputs, advance the model at the edge, check at negedge.
  task automatic cyc(input logic v, input logic [N-1:0] vec, input logic r, input string tag);
    logic acc, fire;
    in_valid  = v;
    in_vec    = vec;
    out_ready = r;
    acc  = v && (q.size() == 0);
    fire = r && (q.size() != 0);
    @(posedge clk);
    if (fire) void'(q.pop_front());
    if (acc) for (int i = 0; i < N; i++) if (vec[i]) q.push_back(i);
    @(negedge clk);
    check_outs(tag);
  endtask

  initial begin
    // 1: reset held for 3 clocks, then release with no beat
    repeat (3) @(negedge clk);
    check_outs("t1_rst");
    rst_n = 1'b1;
    cyc(1'b0, '0, 1'b1, "t1_rel");

    // 2: single high-ish bit
    cyc(1'b1, 4'b0100, 1'b1, "t2_beat");
    cyc(1'b0, '0, 1'b1, "t2_idle");

    // 3: all ones drains 0..3 back to back
    cyc(1'b1, 4'b1111, 1'b1, "t3_acc");
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, "t3_drain");

    // 4: stall with in_vec churning, then drain
    cyc(1'b1, 4'b1010, 1'b0, "t4_acc");
    for (int i = 0; i < 4; i++) cyc(1'b1, N'($urandom), 1'b0, "t4_stall");
    cyc(1'b0, '0, 1'b1, "t4_b1");
    cyc(1'b0, '0, 1'b1, "t4_b3");

    // 5: zero vector is swallowed; next vector still works
    cyc(1'b1, 4'b0000, 1'b1, "t5_zero");
    cyc(1'b1, 4'b0001, 1'b1, "t5_one");
    cyc(1'b0, '0, 1'b1, "t5_idle");

    // 8 (bit N-1 alone)
    cyc(1'b1, 4'b1000, 1'b1, "t_top");
    cyc(1'b0, '0, 1'b1, "t_top_idle");

    // 6: reset mid-drain drops out_valid immediately
    cyc(1'b1, 4'b1001, 1'b1, "t6_acc");
    cyc(1'b0, '0, 1'b1, "t6_b0");
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    check_outs("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, '0, 1'b1, "t6_post");
    cyc(1'b0, '0, 1'b1, "t6_post2");

    // Random traffic with random back-pressure
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom % 2), N'($urandom), 1'(($urandom % 4) != 0), "rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
